tinyalu_apb_initiator: RTL

//   APB3 requester that drives the TinyALU register block's APB responder port (s_apb_*).

---
 rtl/tinyalu_apb_initiator.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/tinyalu_apb_initiator.sv
// APB3 requester for the TinyALU register block: one single-beat transfer in flight,
// SETUP/ACCESS sequencing, optional ACCESS timeout, one-cycle response strobe.
module tinyalu_apb_initiator #(
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_rsp_timeout,
    output logic              o_m_apb_psel,
    output logic              o_m_apb_penable,
    output logic              o_m_apb_pwrite,
    output logic [ADDR_W-1:0] o_m_apb_paddr,
    output logic [DATA_W-1:0] o_m_apb_pwdata,
    input  logic              i_m_apb_pready,
    input  logic [DATA_W-1:0] i_m_apb_prdata,
    input  logic              i_m_apb_pslverr
);

    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit          TO_EN = (TIMEOUT != 0);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]        r_state;
    logic              r_req_ready;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_rsp_timeout;
    logic [CNT_W-1:0]  r_cnt;

    logic [1:0]        w_state_nxt;
    logic              w_req_ready_nxt;
    logic              w_psel_nxt;
    logic              w_penable_nxt;
    logic              w_pwrite_nxt;
    logic [ADDR_W-1:0] w_paddr_nxt;
    logic [DATA_W-1:0] w_pwdata_nxt;
    logic              w_rsp_valid_nxt;
    logic [DATA_W-1:0] w_rsp_rdata_nxt;
    logic              w_rsp_err_nxt;
    logic              w_rsp_timeout_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  w_cnt_inc;

    // Saturating wait-state count; never wraps even when the timeout is disabled
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_req_ready   <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_req_ready   <= w_req_ready_nxt;
            r_psel        <= w_psel_nxt;
            r_penable     <= w_penable_nxt;
            r_pwrite      <= w_pwrite_nxt;
            r_paddr       <= w_paddr_nxt;
            r_pwdata      <= w_pwdata_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    // Next state and next registered outputs; the APB address/data registers double
    // as the request latch, so they only hold non-zero values during SETUP/ACCESS
    always_comb begin
        w_state_nxt       = r_state;
        w_req_ready_nxt   = 1'b0;
        w_psel_nxt        = 1'b0;
        w_penable_nxt     = 1'b0;
        w_pwrite_nxt      = 1'b0;
        w_paddr_nxt       = '0;
        w_pwdata_nxt      = '0;
        w_rsp_valid_nxt   = 1'b0;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_rsp_err_nxt     = r_rsp_err;
        w_rsp_timeout_nxt = r_rsp_timeout;
        w_cnt_nxt         = r_cnt;

        case (r_state)
            S_IDLE: begin
                if (i_req_valid && r_req_ready) begin
                    w_state_nxt  = S_SETUP;
                    w_psel_nxt   = 1'b1;
                    w_pwrite_nxt = i_req_write;
                    w_paddr_nxt  = i_req_addr;
                    w_pwdata_nxt = i_req_wdata;
                end else begin
                    w_req_ready_nxt = 1'b1;
                end
            end
            S_SETUP: begin
                w_state_nxt   = S_ACCESS;
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
                w_pwrite_nxt  = r_pwrite;
                w_paddr_nxt   = r_paddr;
                w_pwdata_nxt  = r_pwdata;
                w_cnt_nxt     = '0;
            end
            S_ACCESS: begin
                if (i_m_apb_pready) begin
                    w_state_nxt       = S_RESP;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_rdata_nxt   = r_pwrite ? '0 : i_m_apb_prdata;
                    w_rsp_err_nxt     = i_m_apb_pslverr;
                    w_rsp_timeout_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (TO_EN && (w_cnt_inc == CNT_W'(TIMEOUT))) begin
                        w_state_nxt       = S_RESP;
                        w_rsp_valid_nxt   = 1'b1;
                        w_rsp_rdata_nxt   = '0;
                        w_rsp_err_nxt     = 1'b1;
                        w_rsp_timeout_nxt = 1'b1;
                    end else begin
                        w_psel_nxt    = 1'b1;
                        w_penable_nxt = 1'b1;
                        w_pwrite_nxt  = r_pwrite;
                        w_paddr_nxt   = r_paddr;
                        w_pwdata_nxt  = r_pwdata;
                    end
                end
            end
            S_RESP: begin
                w_state_nxt     = S_IDLE;
                w_req_ready_nxt = 1'b1;
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_req_ready_nxt = 1'b1;
            end
        endcase
    end

    assign o_req_ready     = r_req_ready;
    assign o_rsp_valid     = r_rsp_valid;
    assign o_rsp_rdata     = r_rsp_rdata;
    assign o_rsp_err       = r_rsp_err;
    assign o_rsp_timeout   = r_rsp_timeout;
    assign o_m_apb_psel    = r_psel;
    assign o_m_apb_penable = r_penable;
    assign o_m_apb_pwrite  = r_pwrite;
    assign o_m_apb_paddr   = r_paddr;
    assign o_m_apb_pwdata  = r_pwdata;

endmodule
